// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of one shared 16-bit ALU, with a one-entry
// result buffer (valid/ready) and a Z/V/N flag register updated by opcode class.

module alu_share_alu (
  input  logic [3:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [7:0]  imm,
  output logic [15:0] res
);
  logic [31:0] rot;

  always_comb begin
    rot = {a, a} >> imm[3:0];
    res = b;
    case (op)
      4'b0000: res = a + b;
      4'b0001: res = a - b;
      4'b0010: res = a ^ b;
      4'b0011: res = a & b;
      4'b0100: res = a << imm[3:0];
      4'b0101: res = $signed(a) >>> imm[3:0];
      4'b0110: res = rot[15:0];
      4'b0111: res = a | b;
      // load/store address: base plus sign-extended byte offset
      4'b1000,
      4'b1001: res = a + {{8{imm[7]}}, imm};
      4'b1010: res = {a[15:8], imm};
      4'b1011: res = {imm, a[7:0]};
      default: res = b;
    endcase
  end
endmodule

module alu_share_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [3:0]  op0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [7:0]  imm0,
  input  logic        req1,
  input  logic [3:0]  op1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic [7:0]  imm1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic [2:0]  flags
);
  logic        prio;
  logic        can_accept;
  logic        accept;
  logic        winner;
  logic [3:0]  sel_op;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic [7:0]  sel_imm;
  logic [15:0] alu_res;
  logic        is_sub;
  logic [16:0] ovf_sum;
  logic        z;
  logic        v;
  logic        n;

  assign can_accept = !rsp_valid || rsp_ready;
  assign gnt0       = can_accept && req0 && (!req1 || !prio);
  assign gnt1       = can_accept && req1 && (!req0 ||  prio);
  assign accept     = gnt0 || gnt1;
  assign winner     = gnt1;

  assign sel_op  = winner ? op1  : op0;
  assign sel_a   = winner ? a1   : a0;
  assign sel_b   = winner ? b1   : b0;
  assign sel_imm = winner ? imm1 : imm0;

  alu_share_alu u_alu (
    .op  (sel_op),
    .a   (sel_a),
    .b   (sel_b),
    .imm (sel_imm),
    .res (alu_res)
  );

  // overflow from a sign-extended 17-bit add, independent of the ALU datapath
  assign is_sub  = (sel_op == 4'b0001);
  assign ovf_sum = {sel_a[15], sel_a}
                 + (is_sub ? {~sel_b[15], ~sel_b} : {sel_b[15], sel_b})
                 + {16'd0, is_sub};
  assign z = (alu_res == 16'd0);
  assign v = ovf_sum[16] ^ ovf_sum[15];
  assign n = alu_res[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 16'd0;
      prio      <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= winner;
      rsp_data  <= alu_res;
      if (RR_EN) prio <= ~winner;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // flags = {Z,V,N}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 3'b000;
    end else if (accept) begin
      case (sel_op)
        4'b0000, 4'b0001:          flags <= {z, v, n};
        4'b0010, 4'b0100,
        4'b0101, 4'b0110:          flags[2] <= z;
        default:                   flags <= flags;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: round-robin and fixed-priority instances
// share stimulus; expected results are queued at accept and checked at output.

module tb_alu_share_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [3:0]  op0 = '0, op1 = '0;
  logic [15:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [7:0]  imm0 = '0, imm1 = '0;
  logic        rsp_ready = 1'b0;
  logic        gnt0, gnt1, rsp_valid, rsp_id;
  logic [15:0] rsp_data;
  logic [2:0]  flags;
  logic        gnt0_fp, gnt1_fp, rsp_valid_fp, rsp_id_fp;
  logic [15:0] rsp_data_fp;
  logic [2:0]  flags_fp;

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic       m_prio = 1'b0;
  logic       m_valid = 1'b0;
  logic [2:0] m_flags = 3'b000;

  always #5 clk = ~clk;

  alu_share_arb #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .imm0(imm0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .imm1(imm1),
    .gnt0(gnt0), .gnt1(gnt1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .flags(flags)
  );

  alu_share_arb #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .imm0(imm0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .imm1(imm1),
    .gnt0(gnt0_fp), .gnt1(gnt1_fp), .rsp_valid(rsp_valid_fp), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id_fp), .rsp_data(rsp_data_fp), .flags(flags_fp)
  );

  function automatic logic [15:0] m_alu(logic [3:0] op, logic [15:0] a, logic [15:0] b, logic [7:0] imm);
    logic signed [15:0] sa;
    logic [15:0] sx;
    int sh;
    sa = a;
    sh = int'(imm[3:0]);
    sx = {{8{imm[7]}}, imm};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a ^ b;
      4'd3:  return a & b;
      4'd4:  return a << sh;
      4'd5:  return sa >>> sh;
      4'd6:  return (sh == 0) ? a : ((a >> sh) | (a << (16 - sh)));
      4'd7:  return a | b;
      4'd8,
      4'd9:  return a + sx;
      4'd10: return {a[15:8], imm};
      4'd11: return {imm, a[7:0]};
      default: return b;
    endcase
  endfunction

  function automatic logic [1:0] exp_gnt();
    logic ca;
    ca = !m_valid || rsp_ready;
    if (!ca) return 2'b00;
    if (req0 && req1) return m_prio ? 2'b10 : 2'b01;
    return {req1, req0};
  endfunction

  // advance one clock, updating the reference model for whatever is accepted
  task automatic step();
    logic [1:0] g;
    logic [3:0] op;
    logic [15:0] a, b, r;
    logic [7:0] imm;
    int s;
    exp_t e;
    g = exp_gnt();
    if (g != 2'b00) begin
      op = g[1] ? op1 : op0;   a = g[1] ? a1 : a0;
      b = g[1] ? b1 : b0;      imm = g[1] ? imm1 : imm0;
      r = m_alu(op, a, b, imm);
      if (op == 4'd0 || op == 4'd1) begin
        s = (op == 4'd0) ? ($signed(a) + $signed(b)) : ($signed(a) - $signed(b));
        m_flags = {r == 16'd0, (s > 32767 || s < -32768), r[15]};
      end else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) begin
        m_flags[2] = (r == 16'd0);
      end
      e.id = g[1]; e.data = r; e.flags = m_flags;
      sb.push_back(e);
      m_prio = ~g[1];
      m_valid = 1'b1;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0000 || rsp_id !== 1'b0) begin failures++; $display("FAIL reset_data got=%h/%b exp=0000/0", rsp_data, rsp_id); end
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", flags); end
    checks++; if ({gnt1, gnt0} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {gnt1, gnt0}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_add();
    exp_t e;
    rsp_ready = 1'b1;
    req0 = 1'b1; op0 = 4'd0; a0 = 16'h0003; b0 = 16'h0004; #1;
    checks++; if ({gnt1, gnt0} !== 2'b01) begin failures++; $display("FAIL add_gnt got=%b exp=01", {gnt1, gnt0}); end
    step(); req0 = 1'b0;
    e = sb.pop_front();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin failures++; $display("FAIL add_vld_id got=%b/%b exp=1/0", rsp_valid, rsp_id); end
    checks++; if (rsp_data !== 16'h0007) begin failures++; $display("FAIL add_data got=%h exp=0007", rsp_data); end
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL add_flags got=%b exp=000", flags); end
  endtask

  // SUB zero, SUB overflow, XOR zero (V/N hold), LLB (flags hold), then others
  task automatic test_ops();
    logic [3:0]  t_op[10]  = '{4'd1, 4'd1, 4'd2, 4'd10, 4'd4, 4'd5, 4'd6, 4'd3, 4'd0, 4'd11};
    logic [15:0] t_a[10]   = '{16'h0005, 16'h8000, 16'h00FF, 16'h1234, 16'h0001, 16'h8000, 16'h0001, 16'hF0F0, 16'h7FFF, 16'h1234};
    logic [15:0] t_b[10]   = '{16'h0005, 16'h0001, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 16'h0001, 16'h0000};
    logic [7:0]  t_imm[10] = '{8'h00, 8'h00, 8'h00, 8'hAB, 8'h04, 8'h0F, 8'h01, 8'h00, 8'h00, 8'hCD};
    logic [15:0] t_res[10] = '{16'h0000, 16'h7FFF, 16'h0000, 16'h12AB, 16'h0010, 16'hFFFF, 16'h8000, 16'h0000, 16'h8000, 16'hCD34};
    logic [2:0]  t_flg[10] = '{3'b100, 3'b010, 3'b110, 3'b110, 3'b010, 3'b010, 3'b010, 3'b010, 3'b011, 3'b011};
    exp_t e;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req1 = 1'b1; op1 = t_op[i]; a1 = t_a[i]; b1 = t_b[i]; imm1 = t_imm[i]; #1;
      checks++; if ({gnt1, gnt0} !== 2'b10) begin failures++; $display("FAIL ops_gnt[%0d] got=%b exp=10", i, {gnt1, gnt0}); end
      step();
      e = sb.pop_front();
      checks++; if (rsp_data !== t_res[i] || e.data !== t_res[i]) begin failures++; $display("FAIL ops_data[%0d] got=%h exp=%h", i, rsp_data, t_res[i]); end
      checks++; if (flags !== t_flg[i] || e.flags !== t_flg[i]) begin failures++; $display("FAIL ops_flags[%0d] got=%b exp=%b", i, flags, t_flg[i]); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1) begin failures++; $display("FAIL ops_vld_id[%0d] got=%b/%b exp=1/1", i, rsp_valid, rsp_id); end
    end
    req1 = 1'b0;
    step();
  endtask

  task automatic test_contention();
    exp_t e;
    logic [1:0] g;
    rsp_ready = 1'b1;
    op0 = 4'd0; op1 = 4'd1; imm0 = 8'h00; imm1 = 8'h00;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a0 = 16'(i * 3); b0 = 16'h0010; a1 = 16'h0100; b1 = 16'(i); #1;
      g = exp_gnt();
      checks++; if ({gnt1, gnt0} !== g || (gnt0 ~^ gnt0_prev_dummy(i))) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, {gnt1, gnt0}, g); end
      checks++; if ({gnt1_fp, gnt0_fp} !== 2'b01) begin failures++; $display("FAIL fp_gnt[%0d] got=%b exp=01", i, {gnt1_fp, gnt0_fp}); end
      step();
      e = sb.pop_front();
      checks++; if (rsp_id !== e.id || rsp_data !== e.data || flags !== e.flags) begin failures++; $display("FAIL rr_rsp[%0d] got=%b/%h/%b exp=%b/%h/%b", i, rsp_id, rsp_data, flags, e.id, e.data, e.flags); end
      checks++; if (rsp_id_fp !== 1'b0) begin failures++; $display("FAIL fp_id[%0d] got=%b exp=0", i, rsp_id_fp); end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  // alternation must start from requester 0 after the preceding drain sequence
  function automatic logic gnt0_prev_dummy(int i);
    return (i % 2 == 0) ? 1'b0 : 1'b1;
  endfunction

  task automatic test_backpressure();
    exp_t e, e2;
    rsp_ready = 1'b1;
    req0 = 1'b1; op0 = 4'd7; a0 = 16'h0F00; b0 = 16'h00F0; #1;
    step();
    e = sb.pop_front();
    checks++; if (rsp_data !== 16'h0FF0 || rsp_id !== 1'b0) begin failures++; $display("FAIL bp_first got=%h/%b exp=0ff0/0", rsp_data, rsp_id); end
    rsp_ready = 1'b0; req1 = 1'b1; op1 = 4'd0; a1 = 16'h1111; b1 = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({gnt1, gnt0, gnt1_fp, gnt0_fp} !== 4'b0000) begin failures++; $display("FAIL bp_gnt[%0d] got=%b exp=0000", i, {gnt1, gnt0, gnt1_fp, gnt0_fp}); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/%h/%b", i, rsp_valid, rsp_data, rsp_id, e.data, e.id); end
    end
    rsp_ready = 1'b1; #1;
    checks++; if ({gnt1, gnt0} !== 2'b10) begin failures++; $display("FAIL bp_release_gnt got=%b exp=10", {gnt1, gnt0}); end
    step();
    e2 = sb.pop_front();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'h3333 || e2.data !== 16'h3333) begin failures++; $display("FAIL bp_release_rsp got=%b/%b/%h exp=1/1/3333", rsp_valid, rsp_id, rsp_data); end
    req0 = 1'b0; req1 = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    rsp_ready = 1'b1;
    req0 = 1'b1; op0 = 4'd1; a0 = 16'h0000; b0 = 16'h0001; #1;
    step();
    e = sb.pop_front();
    checks++; if (rsp_data !== 16'hFFFF || flags !== 3'b001) begin failures++; $display("FAIL rst_pre got=%h/%b exp=ffff/001", rsp_data, flags); end
    req0 = 1'b0; rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_prio = 1'b0; m_valid = 1'b0; m_flags = 3'b000; sb.delete();
    checks++; if (rsp_valid !== 1'b0 || flags !== 3'b000 || rsp_data !== 16'h0000) begin failures++; $display("FAIL rst_async got=%b/%b/%h exp=0/000/0000", rsp_valid, flags, rsp_data); end
    req0 = 1'b1; req1 = 1'b1; #1;
    checks++; if ({gnt1, gnt0} !== 2'b01) begin failures++; $display("FAIL rst_prio got=%b exp=01", {gnt1, gnt0}); end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b1; req0 = 1'b1; req1 = 1'b1; op0 = 4'd0; a0 = 16'h0002; b0 = 16'h0002; #1;
    step();
    req0 = 1'b0; req1 = 1'b0;
    e = sb.pop_front();
    checks++; if (rsp_id !== 1'b0 || rsp_data !== 16'h0004 || e.id !== 1'b0) begin failures++; $display("FAIL rst_after got=%b/%h exp=0/0004", rsp_id, rsp_data); end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_add();
    test_ops();
    test_contention();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
